// File: rtl/cla_1bit.sv
`default_nettype none
// ============================================================================
// Module   : cla_1bit
// Purpose  : Single-bit carry-lookahead adder cell with registered outputs.
//            Forms propagate/generate terms from a and b, then sum and
//            carry-out from those terms and cin. Leaf cell of the
//            carry-lookahead adder tree; optional P/G outputs feed the
//            higher-level lookahead carry unit.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous, active-high reset
//            in_valid  - a/b/cin valid this cycle
//            a, b      - operand bits
//            cin       - carry-in
//            sum       - registered sum bit
//            cout      - registered carry-out
//            out_valid - sum/cout hold a result from a valid input
//            p, g      - registered propagate/generate terms
//                        (present only when CLA_1BIT_PG_EN is defined)
// Config   : CLA_1BIT_PG_EN - enables the p/g output ports and registers
// Revision : 1.0 - initial release
// ============================================================================
module cla_1bit (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
`ifdef CLA_1BIT_PG_EN
  output logic p,
  output logic g,
`endif
  output logic out_valid
);

  logic w_p;
  logic w_g;
  logic w_s;
  logic w_c;

  // Lookahead form: carry is generated locally or propagated from cin.
  assign w_p = a ^ b;
  assign w_g = a & b;
  assign w_s = w_p ^ cin;
  assign w_c = w_g | (w_p & cin);

  // Data registers only load on valid input, so unknown operands presented
  // while in_valid is low never reach the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= 1'b0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= w_s;
        cout <= w_c;
      end
    end
  end

`ifdef CLA_1BIT_PG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= 1'b0;
      g <= 1'b0;
    end else if (in_valid) begin
      p <= w_p;
      g <= w_g;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_1bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_1bit
// Purpose  : Self-checking bench for cla_1bit: directed steps from the test
//            plan followed by randomized operands, reset and valid patterns,
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_1bit;

  logic clk;
  logic rst;
  logic in_valid;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;
  logic out_valid;
`ifdef CLA_1BIT_PG_EN
  logic p;
  logic g;
`endif

  int checks;
  int errors;

  // Reference model state: what the outputs must show after each edge.
  logic exp_sum;
  logic exp_cout;
  logic exp_valid;
  logic exp_p;
  logic exp_g;

  cla_1bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
`ifdef CLA_1BIT_PG_EN
    .p        (p),
    .g        (g),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum"}, sum, exp_sum);
    chk({tag, ".cout"}, cout, exp_cout);
    chk({tag, ".out_valid"}, out_valid, exp_valid);
`ifdef CLA_1BIT_PG_EN
    chk({tag, ".p"}, p, exp_p);
    chk({tag, ".g"}, g, exp_g);
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model
  // from the arithmetic definition, then compare.
  task automatic step(input logic r, input logic v, input logic ia,
                      input logic ib, input logic ic, input string tag);
    int total;
    int ab;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = ia;
    b        = ib;
    cin      = ic;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sum   = 1'b0;
      exp_cout  = 1'b0;
      exp_valid = 1'b0;
      exp_p     = 1'b0;
      exp_g     = 1'b0;
    end else if (v) begin
      ab        = int'(ia) + int'(ib);
      total     = ab + int'(ic);
      exp_sum   = (total % 2) == 1;
      exp_cout  = total >= 2;
      exp_p     = ab == 1;
      exp_g     = ab == 2;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    check_all(tag);
  endtask

  initial begin
    logic [1:0] sweep_exp [8];
    logic [2:0] vec;
    checks = 0;
    errors = 0;
    sweep_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    exp_sum = 1'b0; exp_cout = 1'b0; exp_valid = 1'b0;
    exp_p = 1'b0; exp_g = 1'b0;
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;

    // Reset held two cycles with all-ones valid operands.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset1");
    chk("reset.sum_zero", sum, 1'b0);
    chk("reset.valid_zero", out_valid, 1'b0);

    // Exhaustive sweep, one vector per clock.
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      step(1'b0, 1'b1, vec[2], vec[1], vec[0], "sweep");
      chk("sweep.cout_tbl", cout, sweep_exp[i][1]);
      chk("sweep.sum_tbl", sum, sweep_exp[i][0]);
    end

`ifdef CLA_1BIT_PG_EN
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "pg10");
    chk("pg10.p", p, 1'b1);
    chk("pg10.g", g, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "pg11");
    chk("pg11.p", p, 1'b0);
    chk("pg11.g", g, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pg00");
    chk("pg00.p", p, 1'b0);
    chk("pg00.g", g, 1'b0);
`endif

    // Hold: results persist while in_valid is low.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "hold_load");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "hold_idle");
    chk("hold.sum", sum, 1'b0);
    chk("hold.cout", cout, 1'b1);
    chk("hold.valid_drop", out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "hold_idle2");

    // Reset wins over a simultaneous valid input.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rstprio");
    chk("rstprio.cout", cout, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "rstprio_next");
    chk("rstprio_next.sum", sum, 1'b1);
    chk("rstprio_next.cout", cout, 1'b1);

    // Mid-stream reset drops the second vector.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "mid1");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "mid2");
    chk("mid2.no_valid", out_valid, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "mid3");
    chk("mid3.cout", cout, 1'b1);
    chk("mid3.valid", out_valid, 1'b1);

    // Randomized traffic with occasional resets and idle cycles.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), 1'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
